// File: rtl/fifo_bank_mc_pkg.sv
// ============================================================================
// Module  : fifo_bank_mc_pkg
// Brief   : Shared depth/count-width derivations and pause-state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_bank_mc_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    PAUSE = 1'b1
  } pause_state_e;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  // One extra bit so a completely full channel is distinguishable from empty.
  function automatic int cw_of(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_chan.sv
// ============================================================================
// Module  : fifo_chan
// Brief   : One FIFO channel: storage, pointers, flags, pause FSM, sticky error.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_chan
  import fifo_bank_mc_pkg::*;
#(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  input  logic [ADDR_W:0]   i_af_thr,
  input  logic [ADDR_W:0]   i_ae_thr,
  input  logic              i_err_clr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_almost_full,
  output logic              o_almost_empty,
  output logic              o_pause,
  output logic              o_error,
  output logic [ADDR_W:0]   o_count
);

  localparam int c_depth = depth_of(ADDR_W);
  localparam int c_cw    = cw_of(ADDR_W);

  logic [DATA_W-1:0] r_mem [c_depth];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [c_cw-1:0]   r_count;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_error;
  pause_state_e      r_state;
  pause_state_e      w_next_state;

  logic w_empty, w_full, w_pop_ok, w_push_ok, w_overflow, w_underflow;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == c_cw'(c_depth));
  assign w_pop_ok    = i_pop & ~w_empty;
  // A full channel still accepts a push when a pop frees a slot in the same cycle.
  assign w_push_ok   = i_push & (~w_full | w_pop_ok);
  assign w_overflow  = i_push & w_full & ~w_pop_ok;
  assign w_underflow = i_pop & w_empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_valid <= w_pop_ok;
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_data   <= r_mem[r_rd_ptr];
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + c_cw'(1);
        2'b01:   r_count <= r_count - c_cw'(1);
        default: r_count <= r_count;
      endcase
      if (w_overflow | w_underflow) begin
        r_error <= 1'b1;
      end else if (i_err_clr) begin
        r_error <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Set condition wins so an illegal af_thr <= ae_thr setting resolves to PAUSE.
  always_comb begin
    w_next_state = r_state;
    if (r_count >= i_af_thr) begin
      w_next_state = PAUSE;
    end else if (r_state == PAUSE && r_count <= i_ae_thr) begin
      w_next_state = RUN;
    end
  end

  assign o_data         = r_data;
  assign o_valid        = r_valid;
  assign o_empty        = w_empty;
  assign o_full         = w_full;
  assign o_almost_full  = (r_count >= i_af_thr);
  assign o_almost_empty = (r_count <= i_ae_thr) && !w_empty;
  assign o_pause        = (r_state == PAUSE);
  assign o_error        = r_error;
  assign o_count        = r_count;

endmodule

`default_nettype wire

// File: rtl/fifo_bank_mc.sv
// ============================================================================
// Module  : fifo_bank_mc
// Brief   : Bank of NUM_CH independent FIFO channels with shared thresholds.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_bank_mc
  import fifo_bank_mc_pkg::*;
#(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 3,
  parameter int NUM_CH = 4
) (
  input  logic                       clk,
  input  logic                       reset_L,
  input  logic [NUM_CH-1:0]          push,
  input  logic [NUM_CH-1:0]          pop,
  input  logic [NUM_CH*DATA_W-1:0]   data_in,
  input  logic [ADDR_W:0]            af_thr,
  input  logic [ADDR_W:0]            ae_thr,
  input  logic [NUM_CH-1:0]          err_clr,
  output logic [NUM_CH*DATA_W-1:0]   data_out,
  output logic [NUM_CH-1:0]          valid_out,
  output logic [NUM_CH-1:0]          empty,
  output logic [NUM_CH-1:0]          full,
  output logic [NUM_CH-1:0]          almost_full,
  output logic [NUM_CH-1:0]          almost_empty,
  output logic [NUM_CH-1:0]          pause,
  output logic [NUM_CH-1:0]          error,
  output logic [NUM_CH*(ADDR_W+1)-1:0] count
);

  localparam int c_cw = cw_of(ADDR_W);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fifo_chan #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_chan (
      .clk            (clk),
      .reset_L        (reset_L),
      .i_push         (push[c]),
      .i_pop          (pop[c]),
      .i_data         (data_in[c*DATA_W +: DATA_W]),
      .i_af_thr       (af_thr),
      .i_ae_thr       (ae_thr),
      .i_err_clr      (err_clr[c]),
      .o_data         (data_out[c*DATA_W +: DATA_W]),
      .o_valid        (valid_out[c]),
      .o_empty        (empty[c]),
      .o_full         (full[c]),
      .o_almost_full  (almost_full[c]),
      .o_almost_empty (almost_empty[c]),
      .o_pause        (pause[c]),
      .o_error        (error[c]),
      .o_count        (count[c*c_cw +: c_cw])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_bank_mc.sv
// ============================================================================
// Module  : tb_fifo_bank_mc
// Brief   : Randomized and directed bench for fifo_bank_mc against a queue model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_bank_mc;

  localparam int DW = 6;
  localparam int NC = 4;
  localparam int CW = 4;
  localparam int DEPTH = 8;

  logic                clk = 1'b0;
  logic                reset_L = 1'b0;
  logic [NC-1:0]       push = '0, pop = '0, err_clr = '0;
  logic [NC*DW-1:0]    data_in = '0;
  logic [CW-1:0]       af_thr = 4'd6, ae_thr = 4'd2;
  logic [NC*DW-1:0]    data_out;
  logic [NC-1:0]       valid_out, empty, full, almost_full, almost_empty, pause, error;
  logic [NC*CW-1:0]    count;

  fifo_bank_mc #(.DATA_W(DW), .ADDR_W(3), .NUM_CH(NC)) dut (
    .clk(clk), .reset_L(reset_L), .push(push), .pop(pop), .data_in(data_in),
    .af_thr(af_thr), .ae_thr(ae_thr), .err_clr(err_clr), .data_out(data_out),
    .valid_out(valid_out), .empty(empty), .full(full), .almost_full(almost_full),
    .almost_empty(almost_empty), .pause(pause), .error(error), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per channel plus the registered outputs.
  logic [DW-1:0] q [NC][$];
  logic [DW-1:0] m_data [NC];
  logic          m_valid [NC];
  logic          m_pause [NC];
  logic          m_err [NC];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      q[c].delete();
      m_data[c] = '0; m_valid[c] = 1'b0; m_pause[c] = 1'b0; m_err[c] = 1'b0;
    end
  endtask

  task automatic compare_all();
    logic [NC*CW-1:0] e_cnt;
    logic [NC*DW-1:0] e_dat;
    logic [NC-1:0] e_emp, e_ful, e_af, e_ae, e_val, e_pau, e_err;
    for (int c = 0; c < NC; c++) begin
      int n = q[c].size();
      e_cnt[c*CW +: CW] = CW'(n);
      e_dat[c*DW +: DW] = m_data[c];
      e_emp[c] = (n == 0);
      e_ful[c] = (n == DEPTH);
      e_af[c]  = (n >= int'(af_thr));
      e_ae[c]  = (n <= int'(ae_thr)) && (n != 0);
      e_val[c] = m_valid[c];
      e_pau[c] = m_pause[c];
      e_err[c] = m_err[c];
    end
    chk("count", 32'(count), 32'(e_cnt));
    chk("empty", 32'(empty), 32'(e_emp));
    chk("full", 32'(full), 32'(e_ful));
    chk("almost_full", 32'(almost_full), 32'(e_af));
    chk("almost_empty", 32'(almost_empty), 32'(e_ae));
    chk("valid_out", 32'(valid_out), 32'(e_val));
    chk("data_out", 32'(data_out), 32'(e_dat));
    chk("pause", 32'(pause), 32'(e_pau));
    chk("error", 32'(error), 32'(e_err));
  endtask

  // Entered just after a falling edge; leaves just after the next falling edge.
  task automatic cycle(input logic [NC-1:0] p, input logic [NC-1:0] o,
                       input logic [NC-1:0] clr, input logic [NC*DW-1:0] din);
    push = p; pop = o; err_clr = clr; data_in = din;
    #1;
    compare_all();
    for (int c = 0; c < NC; c++) begin
      int  n = q[c].size();
      bit  pop_ok  = o[c] && (n > 0);
      bit  push_ok = p[c] && ((n < DEPTH) || pop_ok);
      if (pop_ok) m_data[c] = q[c].pop_front();
      m_valid[c] = pop_ok;
      if (push_ok) q[c].push_back(din[c*DW +: DW]);
      if ((p[c] && n == DEPTH && !pop_ok) || (o[c] && n == 0)) m_err[c] = 1'b1;
      else if (clr[c]) m_err[c] = 1'b0;
      if (n >= int'(af_thr)) m_pause[c] = 1'b1;
      else if (m_pause[c] && n <= int'(ae_thr)) m_pause[c] = 1'b0;
    end
    @(negedge clk);
  endtask

  function automatic logic [NC*DW-1:0] on_ch(input int c, input logic [DW-1:0] v);
    logic [NC*DW-1:0] r = '0;
    r[c*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [NC-1:0] bit_of(input int c);
    return NC'(1) << c;
  endfunction

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_empty", 32'(empty), 32'hF);
    chk("reset_count", 32'(count), 32'h0);
    reset_L = 1'b1;
    @(negedge clk);

    // ch0 fill past full, then drain
    for (int i = 1; i <= 9; i++) cycle(bit_of(0), '0, '0, on_ch(0, DW'(i)));
    for (int i = 0; i < 8; i++) cycle('0, bit_of(0), '0, '0);
    cycle('0, '0, bit_of(0), '0);
    cycle('0, '0, '0, '0);

    // ch1 pause hysteresis
    for (int i = 0; i < 6; i++) cycle(bit_of(1), '0, '0, on_ch(1, DW'(20 + i)));
    cycle('0, '0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      cycle('0, bit_of(1), '0, '0);
      cycle('0, '0, '0, '0);
    end
    for (int i = 0; i < 2; i++) cycle('0, bit_of(1), '0, '0);

    // ch2 simultaneous push/pop while full, then drain across the wrap
    for (int i = 0; i < 8; i++) cycle(bit_of(2), '0, '0, on_ch(2, DW'(40 + i)));
    for (int i = 0; i < 3; i++) cycle(bit_of(2), bit_of(2), '0, on_ch(2, DW'(50 + i)));
    for (int i = 0; i < 9; i++) cycle('0, bit_of(2), '0, '0);

    // ch3 underflow and sticky clear
    cycle('0, bit_of(3), '0, '0);
    cycle('0, bit_of(3), bit_of(3), '0);
    cycle('0, '0, bit_of(3), '0);
    cycle('0, '0, '0, '0);

    // random traffic on all channels, thresholds occasionally changed
    for (int i = 0; i < 600; i++) begin
      logic [NC-1:0] p, o, clr;
      bit fill = ((i / 100) % 2) == 0;
      for (int c = 0; c < NC; c++) begin
        p[c] = ($urandom_range(0, 9) < (fill ? 7 : 3));
        o[c] = ($urandom_range(0, 9) < (fill ? 3 : 7));
        clr[c] = ($urandom_range(0, 9) == 0);
      end
      if ($urandom_range(0, 29) == 0) begin
        af_thr = CW'($urandom_range(0, 9));
        ae_thr = CW'($urandom_range(0, 9));
      end
      cycle(p, o, clr, NC*DW'($urandom));
    end

    // asynchronous reset in the middle of a cycle with data queued
    af_thr = 4'd6; ae_thr = 4'd2;
    for (int i = 0; i < 3; i++) cycle('1, '0, '0, NC*DW'($urandom));
    cycle('1, '1, '0, NC*DW'($urandom));
    push = '0; pop = '0; err_clr = '0;
    @(posedge clk);
    #2 reset_L = 1'b0;
    #1;
    model_reset();
    chk("async_rst_count", 32'(count), 32'h0);
    chk("async_rst_empty", 32'(empty), 32'hF);
    chk("async_rst_valid", 32'(valid_out), 32'h0);
    chk("async_rst_data", 32'(data_out), 32'h0);
    chk("async_rst_pause", 32'(pause), 32'h0);
    chk("async_rst_error", 32'(error), 32'h0);
    @(negedge clk);
    reset_L = 1'b1;
    for (int i = 0; i < 4; i++) cycle('0, '1, '0, '0);
    for (int i = 0; i < 3; i++) cycle('1, '0, '0, NC*DW'($urandom));
    for (int i = 0; i < 4; i++) cycle('0, '1, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
